// File: rtl/interconnect_pkg.sv
// Shared AXI4 encodings, widths, FSM state types and response helper for the
// on-chip memory subordinate.
package interconnect_pkg;

    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_RESP_W  = 2;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } w_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    function automatic axi_resp_e resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational AXI burst next-address and error evaluation.
// WRAP bursts are only accepted when AXI_MEM_SUB_WRAP_EN is defined.
module axi_burst_addr
    import interconnect_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_BYTES  = 65536
) (
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [AXI_LEN_W-1:0]   len,
    input  logic [AXI_SIZE_W-1:0]  size,
    input  logic [AXI_BURST_W-1:0] burst,
    output logic [ADDR_WIDTH-1:0]  next_addr,
    output logic                   burst_err,
    output logic                   out_of_range
);

    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);
    localparam int MEM_AW   = $clog2(MEM_BYTES);
`ifdef AXI_MEM_SUB_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic [ADDR_WIDTH-1:0] step_s;
    logic [ADDR_WIDTH-1:0] aligned_s;
    logic [ADDR_WIDTH-1:0] incr_s;
    logic [ADDR_WIDTH-1:0] wrap_bytes_s;
    logic [ADDR_WIDTH-1:0] wrap_base_s;
    logic                  size_err_s;
    logic                  wrap_ok_s;

    // Address arithmetic and per-burst legality checks.
    always_comb begin
        step_s       = ADDR_WIDTH'(1'b1) << size;
        aligned_s    = addr & ~(step_s - ADDR_WIDTH'(1'b1));
        incr_s       = aligned_s + step_s;
        wrap_bytes_s = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1'b1)) << size;
        wrap_base_s  = addr & ~(wrap_bytes_s - ADDR_WIDTH'(1'b1));
        size_err_s   = (size > AXI_SIZE_W'(MAX_SIZE));
        wrap_ok_s    = ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15))
                       && (aligned_s == addr);
        out_of_range = |addr[ADDR_WIDTH-1:MEM_AW];
        case (burst)
            BURST_FIXED: begin
                next_addr = addr;
                burst_err = size_err_s;
            end
            BURST_INCR: begin
                next_addr = incr_s;
                burst_err = size_err_s;
            end
            BURST_WRAP: begin
                if (WRAP_EN) begin
                    next_addr = (incr_s == (wrap_base_s + wrap_bytes_s)) ? wrap_base_s : incr_s;
                    burst_err = size_err_s || !wrap_ok_s;
                end else begin
                    next_addr = incr_s;
                    burst_err = 1'b1;
                end
            end
            default: begin
                next_addr = addr;
                burst_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/axi_mem_subordinate.sv
// AXI4 subordinate backed by an inferred byte-enable SRAM; independent read and
// write engines, one burst in flight per direction. WRAP gated by AXI_MEM_SUB_WRAP_EN.
module axi_mem_subordinate
    import interconnect_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_BYTES  = 65536
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int MEM_AW = $clog2(MEM_BYTES);
    localparam int WORDS  = MEM_BYTES / BYTES;

    logic [DATA_WIDTH-1:0] mem [0:WORDS-1];
    logic [DATA_WIDTH-1:0] mem_rdata_r;

    // ---------------- write engine state ----------------
    w_state_e              w_state_r;
    logic                  awready_r, wready_r, bvalid_r;
    logic [ID_WIDTH-1:0]   bid_r;
    axi_resp_e             bresp_r;
    logic [ADDR_WIDTH-1:0] waddr_r;
    logic [7:0]            wlen_r, wcnt_r;
    logic [2:0]            wsize_r;
    logic [1:0]            wburst_r;
    logic                  wburst_err_r, wany_err_r;
    logic [ADDR_WIDTH-1:0] wg_addr_s, w_next_s;
    logic [7:0]            wg_len_s;
    logic [2:0]            wg_size_s;
    logic [1:0]            wg_burst_s;
    logic                  w_err_s, w_oor_s, mem_we_s;

    // ---------------- read engine state ----------------
    r_state_e              r_state_r;
    logic                  arready_r, rvalid_r, rlast_r, rmask_r, rdone_r;
    logic [ID_WIDTH-1:0]   rid_r;
    axi_resp_e             rresp_r;
    logic [ADDR_WIDTH-1:0] raddr_r;
    logic [7:0]            rlen_r, rcnt_r;
    logic [2:0]            rsize_r;
    logic [1:0]            rburst_r;
    logic                  rburst_err_r;
    logic [ADDR_WIDTH-1:0] rg_addr_s, r_next_s;
    logic [7:0]            rg_len_s;
    logic [2:0]            rg_size_s;
    logic [1:0]            rg_burst_s;
    logic                  r_err_s, r_oor_s, issue_s, mem_re_s;

    // While idle the generators see the incoming request so burst errors latch at the handshake.
    always_comb begin
        if (w_state_r == W_IDLE) begin
            wg_addr_s  = s_axi_awaddr;
            wg_len_s   = s_axi_awlen;
            wg_size_s  = s_axi_awsize;
            wg_burst_s = s_axi_awburst;
        end else begin
            wg_addr_s  = waddr_r;
            wg_len_s   = wlen_r;
            wg_size_s  = wsize_r;
            wg_burst_s = wburst_r;
        end
        if (r_state_r == R_IDLE) begin
            rg_addr_s  = s_axi_araddr;
            rg_len_s   = s_axi_arlen;
            rg_size_s  = s_axi_arsize;
            rg_burst_s = s_axi_arburst;
        end else begin
            rg_addr_s  = raddr_r;
            rg_len_s   = rlen_r;
            rg_size_s  = rsize_r;
            rg_burst_s = rburst_r;
        end
    end

    axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MEM_BYTES(MEM_BYTES)) u_waddr (
        .addr(wg_addr_s), .len(wg_len_s), .size(wg_size_s), .burst(wg_burst_s),
        .next_addr(w_next_s), .burst_err(w_err_s), .out_of_range(w_oor_s)
    );

    axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MEM_BYTES(MEM_BYTES)) u_raddr (
        .addr(rg_addr_s), .len(rg_len_s), .size(rg_size_s), .burst(rg_burst_s),
        .next_addr(r_next_s), .burst_err(r_err_s), .out_of_range(r_oor_s)
    );

    // SRAM access strobes; a read is issued only when the R register is free or draining.
    always_comb begin
        mem_we_s = (w_state_r == W_DATA) && s_axi_wvalid && wready_r && !wburst_err_r && !w_oor_s;
        issue_s  = (r_state_r == R_DATA) && !rdone_r && (!rvalid_r || s_axi_rready);
        mem_re_s = issue_s && !rburst_err_r && !r_oor_s;
    end

    // Byte-enable SRAM, read-first on a same-cycle collision; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_re_s) begin
            mem_rdata_r <= mem[raddr_r[MEM_AW-1:OFF_W]];
        end
        for (int b = 0; b < BYTES; b++) begin
            if (mem_we_s && s_axi_wstrb[b]) begin
                mem[waddr_r[MEM_AW-1:OFF_W]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    // Write FSM: AW accept, W drain to wlast with sticky error, then hold B until bready.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_r    <= W_IDLE;
            awready_r    <= 1'b0;
            wready_r     <= 1'b0;
            bvalid_r     <= 1'b0;
            bid_r        <= '0;
            bresp_r      <= RESP_OKAY;
            waddr_r      <= '0;
            wlen_r       <= 8'd0;
            wcnt_r       <= 8'd0;
            wsize_r      <= 3'd0;
            wburst_r     <= 2'd0;
            wburst_err_r <= 1'b0;
            wany_err_r   <= 1'b0;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (s_axi_awvalid && awready_r) begin
                        bid_r        <= s_axi_awid;
                        waddr_r      <= s_axi_awaddr;
                        wlen_r       <= s_axi_awlen;
                        wsize_r      <= s_axi_awsize;
                        wburst_r     <= s_axi_awburst;
                        wburst_err_r <= w_err_s;
                        wany_err_r   <= w_err_s;
                        wcnt_r       <= 8'd0;
                        awready_r    <= 1'b0;
                        wready_r     <= 1'b1;
                        w_state_r    <= W_DATA;
                    end else begin
                        awready_r    <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (s_axi_wvalid && wready_r) begin
                        waddr_r <= w_next_s;
                        wcnt_r  <= wcnt_r + 8'd1;
                        if (s_axi_wlast) begin
                            wready_r  <= 1'b0;
                            bvalid_r  <= 1'b1;
                            bresp_r   <= resp_of(wany_err_r || w_oor_s || (wcnt_r != wlen_r));
                            w_state_r <= W_RESP;
                        end else begin
                            // Reaching beat awlen without wlast means the burst is over-long.
                            wany_err_r <= wany_err_r || w_oor_s || (wcnt_r == wlen_r);
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        w_state_r <= W_IDLE;
                    end
                end
                default: begin
                    w_state_r <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: AR accept, then one SRAM read per free R slot until the last beat drains.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_r    <= R_IDLE;
            arready_r    <= 1'b0;
            rvalid_r     <= 1'b0;
            rlast_r      <= 1'b0;
            rmask_r      <= 1'b0;
            rdone_r      <= 1'b0;
            rid_r        <= '0;
            rresp_r      <= RESP_OKAY;
            raddr_r      <= '0;
            rlen_r       <= 8'd0;
            rcnt_r       <= 8'd0;
            rsize_r      <= 3'd0;
            rburst_r     <= 2'd0;
            rburst_err_r <= 1'b0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (s_axi_arvalid && arready_r) begin
                        rid_r        <= s_axi_arid;
                        raddr_r      <= s_axi_araddr;
                        rlen_r       <= s_axi_arlen;
                        rsize_r      <= s_axi_arsize;
                        rburst_r     <= s_axi_arburst;
                        rburst_err_r <= r_err_s;
                        rcnt_r       <= 8'd0;
                        rdone_r      <= 1'b0;
                        arready_r    <= 1'b0;
                        r_state_r    <= R_DATA;
                    end else begin
                        arready_r    <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (issue_s) begin
                        rvalid_r <= 1'b1;
                        rresp_r  <= resp_of(rburst_err_r || r_oor_s);
                        rmask_r  <= !(rburst_err_r || r_oor_s);
                        rlast_r  <= (rcnt_r == rlen_r);
                        rdone_r  <= (rcnt_r == rlen_r);
                        raddr_r  <= r_next_s;
                        rcnt_r   <= rcnt_r + 8'd1;
                    end else if (rvalid_r && s_axi_rready) begin
                        rvalid_r <= 1'b0;
                        rlast_r  <= 1'b0;
                        if (rlast_r) begin
                            arready_r <= 1'b1;
                            r_state_r <= R_IDLE;
                        end
                    end
                end
                default: begin
                    r_state_r <= R_IDLE;
                end
            endcase
        end
    end

    assign s_axi_awready = awready_r;
    assign s_axi_wready  = wready_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bid     = bid_r;
    assign s_axi_bresp   = bresp_r;
    assign s_axi_arready = arready_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rid     = rid_r;
    assign s_axi_rresp   = rresp_r;
    assign s_axi_rlast   = rlast_r;
    // Erroring and out-of-range beats return zero without touching the SRAM.
    assign s_axi_rdata   = rmask_r ? mem_rdata_r : '0;

endmodule
